// File: rtl/user_bus_arbiter.sv
// user_bus_arbiter
//   Round-robin arbiter sharing one downstream register/memory port between
//   the management-SoC Wishbone slave (wbs_*) and a logic-analyzer request
//   channel (la_*). One outstanding transaction at a time.
//
//   Optional feature macro: ARB_TIMEOUT_EN
//     defined   -> a stalled slave is aborted after TIMEOUT busy cycles; the
//                  requester gets an ack with 32'hDEAD_BEEF and err_o sticks.
//     undefined -> BUSY waits indefinitely, err_o is tied low.
//
// Ports
//   wb_clk_i, wb_rst_i         clock, async active-high reset
//   wbs_cyc/stb/we/sel/adr/dat request from the Wishbone master
//   wbs_ack_o, wbs_dat_o       one-cycle ack and read data to Wishbone
//   la_req/we/sel/adr/dat      request from the logic-analyzer channel
//   la_ack_o, la_dat_o         one-cycle ack and read data to LA
//   m_stb/we/sel/adr/dat_o     downstream request (payload held while stb)
//   m_ack_i, m_dat_i           downstream acknowledge and read data
//   grant_o                    {LA,WB} owner of the current transaction
//   err_o                      sticky timeout flag
module user_bus_arbiter #(
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          wbs_cyc_i,
    input  logic          wbs_stb_i,
    input  logic          wbs_we_i,
    input  logic [3:0]    wbs_sel_i,
    input  logic [AW-1:0] wbs_adr_i,
    input  logic [DW-1:0] wbs_dat_i,
    output logic          wbs_ack_o,
    output logic [DW-1:0] wbs_dat_o,
    input  logic          la_req_i,
    input  logic          la_we_i,
    input  logic [3:0]    la_sel_i,
    input  logic [AW-1:0] la_adr_i,
    input  logic [DW-1:0] la_dat_i,
    output logic          la_ack_o,
    output logic [DW-1:0] la_dat_o,
    output logic          m_stb_o,
    output logic          m_we_o,
    output logic [3:0]    m_sel_o,
    output logic [AW-1:0] m_adr_o,
    output logic [DW-1:0] m_dat_o,
    input  logic          m_ack_i,
    input  logic [DW-1:0] m_dat_i,
    output logic [1:0]    grant_o,
    output logic          err_o
);

    typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

    state_t        state, state_next;
    logic          wb_req, la_req;
    logic          pick_la;     // LA wins the arbitration this cycle
    logic          grant_en;    // IDLE -> BUSY: latch winner payload
    logic          done;        // BUSY -> ACK: slave ack or abort
    logic          expire;      // watchdog fired this cycle
    logic          last_la;     // previous owner was LA
    logic [DW-1:0] rdata;

    assign wb_req  = wbs_cyc_i & wbs_stb_i;
    assign la_req  = la_req_i;
    // Tie goes to whoever was not served last; a lone requester always wins.
    assign pick_la = la_req & (~wb_req | ~last_la);

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        grant_en   = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: if (wb_req | la_req) begin
                grant_en   = 1'b1;
                state_next = BUSY;
            end
            BUSY: if (m_ack_i | expire) begin
                done       = 1'b1;
                state_next = ACK;
            end
            ACK:     state_next = IDLE;   // never re-arbitrate in ACK
            default: state_next = IDLE;
        endcase
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt;

    // Counts consecutive BUSY cycles without a slave ack.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i)                   cnt <= '0;
        else if (state == BUSY && !m_ack_i) cnt <= cnt + 1'b1;
        else                            cnt <= '0;
    end

    // A coincident slave ack takes priority over expiry.
    assign expire = (state == BUSY) && !m_ack_i && (cnt == CW'(TIMEOUT - 1));
    assign rdata  = expire ? DW'(32'hDEAD_BEEF) : m_dat_i;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i)    err_o <= 1'b0;
        else if (expire) err_o <= 1'b1;
    end
`else
    assign expire = 1'b0;
    assign rdata  = m_dat_i;
    assign err_o  = 1'b0;
`endif

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            m_stb_o   <= 1'b0;
            m_we_o    <= 1'b0;
            m_sel_o   <= '0;
            m_adr_o   <= '0;
            m_dat_o   <= '0;
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            la_ack_o  <= 1'b0;
            la_dat_o  <= '0;
            grant_o   <= '0;
            last_la   <= 1'b1;
        end else begin
            wbs_ack_o <= 1'b0;
            la_ack_o  <= 1'b0;
            if (grant_en) begin
                grant_o <= pick_la ? 2'b10 : 2'b01;
                m_stb_o <= 1'b1;
                m_we_o  <= pick_la ? la_we_i  : wbs_we_i;
                m_sel_o <= pick_la ? la_sel_i : wbs_sel_i;
                m_adr_o <= pick_la ? la_adr_i : wbs_adr_i;
                m_dat_o <= pick_la ? la_dat_i : wbs_dat_i;
            end
            if (done) begin
                m_stb_o <= 1'b0;
                if (grant_o[1]) begin
                    la_ack_o <= 1'b1;
                    la_dat_o <= rdata;
                end else begin
                    wbs_ack_o <= 1'b1;
                    wbs_dat_o <= rdata;
                end
            end
            if (state == ACK) begin
                grant_o <= '0;
                last_la <= grant_o[1];
            end
        end
    end

endmodule

// File: tb/tb_user_bus_arbiter.sv
module tb_user_bus_arbiter;

    localparam int TMO = 4;
`ifdef ARB_TIMEOUT_EN
    localparam int MAXW = TMO - 2;
`else
    localparam int MAXW = 5;
`endif

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic        wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
    logic [3:0]  wbs_sel_i = '0;
    logic [31:0] wbs_adr_i = '0, wbs_dat_i = '0;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        la_req_i = 1'b0, la_we_i = 1'b0;
    logic [3:0]  la_sel_i = '0;
    logic [31:0] la_adr_i = '0, la_dat_i = '0;
    logic        la_ack_o;
    logic [31:0] la_dat_o;
    logic        m_stb_o, m_we_o;
    logic [3:0]  m_sel_o;
    logic [31:0] m_adr_o, m_dat_o;
    logic        m_ack_i = 1'b0;
    logic [31:0] m_dat_i = '0;
    logic [1:0]  grant_o;
    logic        err_o;

    user_bus_arbiter #(.DW(32), .AW(32), .TIMEOUT(TMO)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .la_req_i(la_req_i), .la_we_i(la_we_i), .la_sel_i(la_sel_i),
        .la_adr_i(la_adr_i), .la_dat_i(la_dat_i),
        .la_ack_o(la_ack_o), .la_dat_o(la_dat_o),
        .m_stb_o(m_stb_o), .m_we_o(m_we_o), .m_sel_o(m_sel_o),
        .m_adr_o(m_adr_o), .m_dat_o(m_dat_o),
        .m_ack_i(m_ack_i), .m_dat_i(m_dat_i),
        .grant_o(grant_o), .err_o(err_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: who was served last, what each read port should show.
    bit          exp_last_la = 1'b1;
    logic [31:0] exp_wb_dat  = '0;
    logic [31:0] exp_la_dat  = '0;
    logic        exp_err     = 1'b0;

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_hold();
        chk("wb_dat", wbs_dat_o, exp_wb_dat);
        chk("la_dat", la_dat_o, exp_la_dat);
        chk("err", err_o, exp_err);
    endtask

    // Serve one transaction starting from an idle arbiter. The slave acks in
    // busy cycle wt+1; with tmo set it never acks and the watchdog aborts.
    task automatic serve(input int wt, input logic [31:0] rd, input bit tmo);
        bit          wl;
        logic [1:0]  g;
        logic [68:0] pay;
        logic [31:0] got;
        wl  = !((wbs_cyc_i & wbs_stb_i) && (!la_req_i || exp_last_la));
        g   = wl ? 2'b10 : 2'b01;
        pay = wl ? {la_we_i, la_sel_i, la_adr_i, la_dat_i}
                 : {wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i};
        tick();
        for (int i = 0; i <= wt; i++) begin
            chk("stb_busy", m_stb_o, 1'b1);
            chk("grant_busy", grant_o, g);
            chk("payload", {m_we_o, m_sel_o, m_adr_o, m_dat_o}, pay);
            chk("ack_busy", {wbs_ack_o, la_ack_o}, 2'b00);
            if (i == wt && !tmo) begin
                m_ack_i = 1'b1;
                m_dat_i = rd;
            end
            tick();
            m_ack_i = 1'b0;
            m_dat_i = $urandom;
        end
        got = tmo ? 32'hDEAD_BEEF : rd;
        if (tmo) exp_err = 1'b1;
        if (wl) exp_la_dat = got;
        else    exp_wb_dat = got;
        chk("ack", {wbs_ack_o, la_ack_o}, wl ? 2'b01 : 2'b10);
        chk("grant_ack", grant_o, g);
        chk("stb_ack", m_stb_o, 1'b0);
        chk_hold();
        tick();
        chk("idle", {m_stb_o, wbs_ack_o, la_ack_o, grant_o}, 5'b0);
        chk_hold();
        if (wl) la_req_i = 1'b0;
        else begin
            wbs_cyc_i = 1'b0;
            wbs_stb_i = 1'b0;
        end
        exp_last_la = wl;
    endtask

    task automatic set_wb(input logic we, input logic [3:0] sel, input logic [31:0] adr, input logic [31:0] dat);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
        wbs_we_i = we; wbs_sel_i = sel; wbs_adr_i = adr; wbs_dat_i = dat;
    endtask

    task automatic set_la(input logic we, input logic [3:0] sel, input logic [31:0] adr, input logic [31:0] dat);
        la_req_i = 1'b1;
        la_we_i = we; la_sel_i = sel; la_adr_i = adr; la_dat_i = dat;
    endtask

    initial begin
        // Reset state
        #3;
        chk("rst_ctrl", {m_stb_o, wbs_ack_o, la_ack_o, grant_o, err_o, m_we_o, m_sel_o}, '0);
        chk("rst_data", {m_adr_o, m_dat_o, wbs_dat_o, la_dat_o}, '0);
        tick(); tick();
        wb_rst_i = 1'b0;

        // First tie after reset: WB then LA, LA strobe two cycles after WB ack
        set_wb(1'b0, 4'hF, 32'h3000_0000, 32'h0);
        set_la(1'b0, 4'h3, 32'h0000_0020, 32'h0);
        serve(0, 32'hCAFE_0001, 1'b0);
        serve(1, 32'hCAFE_0002, 1'b0);

        // WB read, slave acks in first busy cycle
        set_wb(1'b0, 4'hF, 32'h3000_0004, 32'h0);
        serve(0, 32'h1234_5678, 1'b0);
        tick();
        chk("wb_ack_single", wbs_ack_o, 1'b0);

        // LA write, slave waits 3 cycles
        set_la(1'b1, 4'hF, 32'h0000_0010, 32'hA5A5_A5A5);
        serve(3, 32'h0BAD_F00D, 1'b0);

        // Randomized mixes of requesters, payloads and slave latency
        for (int it = 0; it < 30; it++) begin
            int mode;
            mode = $urandom_range(1, 3);
            if (mode != 2)
                set_wb(1'($urandom), 4'($urandom), $urandom, $urandom);
            else begin
                wbs_cyc_i = 1'($urandom);   // cyc without stb is not a request
                wbs_stb_i = 1'b0;
            end
            if (mode != 1)
                set_la(1'($urandom), 4'($urandom), $urandom, $urandom);
            while ((wbs_cyc_i & wbs_stb_i) || la_req_i)
                serve($urandom_range(0, MAXW), $urandom, 1'b0);
            wbs_cyc_i = 1'b0;
            if ($urandom_range(0, 1) == 1) tick();
        end

`ifdef ARB_TIMEOUT_EN
        // Ack coinciding with expiry: ack wins, no error
        set_wb(1'b0, 4'hF, 32'h3000_0008, 32'h0);
        serve(TMO - 1, 32'h5555_AAAA, 1'b0);
        // Slave never acks: abort with DEAD_BEEF, err sticks
        set_la(1'b0, 4'hF, 32'h0000_0040, 32'h0);
        serve(TMO - 1, 32'h0, 1'b1);
        set_wb(1'b1, 4'h1, 32'h3000_000C, 32'h7);
        serve(0, 32'h1111_2222, 1'b0);
`endif

        // Reset mid-BUSY drops the transaction, then WB is re-served first
        set_wb(1'b0, 4'hF, 32'h3000_0010, 32'h0);
        tick();
        set_la(1'b0, 4'hC, 32'h0000_0030, 32'h0);
        tick();
        wb_rst_i = 1'b1;
        #1;
        exp_wb_dat = '0; exp_la_dat = '0; exp_err = 1'b0; exp_last_la = 1'b1;
        chk("rst_async", {m_stb_o, wbs_ack_o, la_ack_o, grant_o}, 5'b0);
        chk("rst_async_adr", m_adr_o, 32'h0);
        chk_hold();
        tick();
        wb_rst_i = 1'b0;
        while ((wbs_cyc_i & wbs_stb_i) || la_req_i)
            serve($urandom_range(0, MAXW), $urandom, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/user_bus_arbiter.md
# user_bus_arbiter

Two-master, one-slave arbiter for the user project area. It shares a single downstream register/memory port between the management-SoC Wishbone slave interface (`wbs_*`) and a logic-analyzer-driven request channel (`la_*`). Arbitration is round-robin, with one outstanding transaction at a time and an optional watchdog on a stalled slave. It sits directly behind the wrapper's Wishbone pins, in front of the user register bank.

## Interface
- `DW`, 32, data width.
- `AW`, 32, address width.
- `TIMEOUT`, 255, slave-wait cycles before abort; must be ≥1; only used with `ARB_TIMEOUT_EN`.

Ports:
- `wb_clk_i`  in  1  sole clock.
- `wb_rst_i`  in  1  reset, asynchronous, active-high.
- `wbs_cyc_i`, `wbs_stb_i`, `wbs_we_i`  in  1 each  Wishbone request qualifiers.
- `wbs_sel_i`  in  4  byte selects.
- `wbs_adr_i`  in  AW  address.
- `wbs_dat_i`  in  DW  write data.
- `wbs_ack_o`  out  1  one-cycle acknowledge.
- `wbs_dat_o`  out  DW  read data, valid with ack.
- `la_req_i`, `la_we_i`  in  1 each  LA request (level) and write enable.
- `la_sel_i`  in  4  byte selects.
- `la_adr_i`  in  AW  address.
- `la_dat_i`  in  DW  write data.
- `la_ack_o`  out  1  one-cycle acknowledge.
- `la_dat_o`  out  DW  read data, valid with ack.
- `m_stb_o`, `m_we_o`  out  1 each  downstream strobe and write.
- `m_sel_o`  out  4  downstream byte selects.
- `m_adr_o`  out  AW  downstream address.
- `m_dat_o`  out  DW  downstream write data.
- `m_ack_i`  in  1  downstream acknowledge.
- `m_dat_i`  in  DW  downstream read data.
- `grant_o`  out  2  {LA,WB} owner of current transaction, one-hot or 0.
- `err_o`  out  1  sticky timeout flag.

## Operation
- Request definitions:
  - WB request = `wbs_cyc_i & wbs_stb_i`.
  - LA request = `la_req_i`.
  - Each requester holds its request and payload stable until its ack, and drops the request in the cycle after the ack.
- FSM states: IDLE, BUSY, ACK.
- IDLE:
  - At a clock edge with any request, grant a requester and latch its we/sel/adr/dat into the `m_*` registers.
  - Set `grant_o` and go to BUSY.
  - If both request, grant the one not granted last. `last` resets to LA, so WB wins the first tie.
- BUSY:
  - `m_stb_o`=1.
  - At the edge where `m_ack_i`=1: capture `m_dat_i` into the winner's `*_dat_o`, drop `m_stb_o`, go to ACK.
- ACK:
  - The winner's `*_ack_o`=1 for exactly one cycle.
  - `grant_o` is held; `last` is updated.
  - Next state is IDLE unconditionally. The ACK cycle is never used to re-arbitrate.
- The loser's request stays pending and is served next. The loser's ack and data outputs never toggle.
- Read data outputs hold their last value between acks. On writes, `*_dat_o` captures `m_dat_i` anyway; don't care.
- Reset at any time:
  - All outputs go to 0 immediately: `m_stb_o`, both acks, `grant_o`, `err_o`, all data and address outputs.
  - State returns to IDLE and `last`=LA.
  - An in-flight transaction is dropped with no ack.

## Timing
- Request visible before edge 0 → `m_stb_o` high in cycle 1.
- Slave acks in cycle k≥1 → requester ack high in cycle k+1.
- Minimum request-to-ack latency: 2 cycles.
- Back-to-back service of a pending loser: its `m_stb_o` rises 2 cycles after the winner's ack cycle (ACK → IDLE → BUSY).
- `m_*` payload is stable for the whole time `m_stb_o` is high.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - A counter runs while in BUSY. It reaches `TIMEOUT` after `TIMEOUT` consecutive BUSY cycles without `m_ack_i`.
  - On reaching `TIMEOUT`: abort, with `m_stb_o` low and transition to ACK.
  - The winner receives an ack with `*_dat_o`=32'hDEAD_BEEF.
  - `err_o` is set and stays set until reset.
  - If `m_ack_i` and expiry coincide, the ack wins and no error is raised.
- `ARB_TIMEOUT_EN` undefined:
  - No counter; BUSY waits indefinitely.
  - `err_o` is tied to 0.

## Test plan
- WB read 0x3000_0004, slave acks first BUSY cycle with 0x1234_5678 → `wbs_ack_o` high in cycle 2 only, `wbs_dat_o`=0x1234_5678, `grant_o`=01.
- WB and LA both request at the same edge after reset → WB served first (`grant_o`=01), then LA (`grant_o`=10). `m_stb_o` for LA rises 2 cycles after `wbs_ack_o`.
- LA write adr 0x10, dat 0xA5A5_A5A5, sel 0xF, slave waits 3 cycles → `m_*` stable for all 4 strobe cycles, `la_ack_o` high one cycle after `m_ack_i`.
- `ARB_TIMEOUT_EN`, `TIMEOUT`=4, slave never acks → `m_stb_o` high for 4 cycles, ack with 0xDEAD_BEEF, `err_o`=1 and sticky. A second case acks exactly at cycle 4 → no error.
- Assert `wb_rst_i` mid-BUSY → `m_stb_o`, `grant_o` and acks go to 0 asynchronously. After release, the pending WB request is re-served normally.
